// File: rtl/mux_sel_arbiter_if.sv
// Handshake bundle between two requesters, the downstream 2:1 mux and the
// arbiter that owns the mux select. The arbiter connects through the slave
// modport; whatever drives the requests and ready connects through master.
interface mux_sel_arbiter_if #(
    parameter int CNT_W = 4
);
    logic             req0;
    logic             req1;
    logic             last0;
    logic             last1;
    logic             ready;
    logic             sel;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             err;
    logic [CNT_W-1:0] beat_cnt;

    modport master (
        output req0, req1, last0, last1, ready,
        input  sel, gnt0, gnt1, busy, err, beat_cnt
    );

    modport slave (
        input  req0, req1, last0, last1, ready,
        output sel, gnt0, gnt1, busy, err, beat_cnt
    );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Two-requester round-robin arbiter driving a downstream 2:1 mux select.
// A grant is locked until the owner's last beat is accepted or the beat
// watchdog forces a release; releases hand off without an idle cycle.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no owner, arbitrate every cycle
// OWN0  | requester 0 owns the mux, counting its accepted beats
// OWN1  | requester 1 owns the mux, counting its accepted beats
module mux_sel_arbiter #(
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    mux_sel_arbiter_if.slave      io_bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_ptr;
    logic             r_sel;
    logic             r_err;
    logic [CNT_W-1:0] r_beat_cnt;

    logic   w_acc0;
    logic   w_acc1;
    logic   w_at_max;
    state_t w_arb_idle;
    state_t w_arb_rel0;
    state_t w_arb_rel1;

    // ptr holds the last owner: the other requester wins a tie.
    function automatic state_t f_arb(input logic a_req0, input logic a_req1,
                                     input logic a_ptr);
        state_t v_nxt;
        if (a_req0 && a_req1) v_nxt = a_ptr ? OWN0 : OWN1;
        else if (a_req0)      v_nxt = OWN0;
        else if (a_req1)      v_nxt = OWN1;
        else                  v_nxt = IDLE;
        return v_nxt;
    endfunction

    // Select follows the owner and holds its last value while idle.
    function automatic logic f_sel(input state_t a_nxt, input logic a_cur);
        logic v_sel;
        if (a_nxt == OWN1)      v_sel = 1'b1;
        else if (a_nxt == OWN0) v_sel = 1'b0;
        else                    v_sel = a_cur;
        return v_sel;
    endfunction

    // Beat acceptance and next-owner candidates for idle and the two release cases.
    assign w_acc0     = (r_state == OWN0) && io_bus.req0 && io_bus.ready;
    assign w_acc1     = (r_state == OWN1) && io_bus.req1 && io_bus.ready;
    assign w_at_max   = (r_beat_cnt == CNT_W'(MAX_BEATS - 1));
    assign w_arb_idle = f_arb(io_bus.req0, io_bus.req1, r_ptr);
    assign w_arb_rel0 = f_arb(io_bus.req0, io_bus.req1, 1'b0);
    assign w_arb_rel1 = f_arb(io_bus.req0, io_bus.req1, 1'b1);

    // Ownership FSM with priority pointer, beat counter, select and watchdog pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_ptr      <= 1'b1;
            r_sel      <= 1'b0;
            r_err      <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_state <= w_arb_idle;
                    r_sel   <= f_sel(w_arb_idle, r_sel);
                end
                OWN0: begin
                    if (w_acc0) begin
                        if (io_bus.last0 || w_at_max) begin
                            r_ptr      <= 1'b0;
                            r_beat_cnt <= '0;
                            r_err      <= ~io_bus.last0;
                            r_state    <= w_arb_rel0;
                            r_sel      <= f_sel(w_arb_rel0, r_sel);
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        end
                    end
                end
                OWN1: begin
                    if (w_acc1) begin
                        if (io_bus.last1 || w_at_max) begin
                            r_ptr      <= 1'b1;
                            r_beat_cnt <= '0;
                            r_err      <= ~io_bus.last1;
                            r_state    <= w_arb_rel1;
                            r_sel      <= f_sel(w_arb_rel1, r_sel);
                        end else begin
                            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign io_bus.gnt0     = (r_state == OWN0);
    assign io_bus.gnt1     = (r_state == OWN1);
    assign io_bus.busy     = (r_state == OWN0) || (r_state == OWN1);
    assign io_bus.sel      = r_sel;
    assign io_bus.err      = r_err;
    assign io_bus.beat_cnt = r_beat_cnt;

endmodule
